// File: rtl/synarray_access_sequencer.sv
// synarray_access_sequencer: sweeps one pre-neuron row of the weight/gradient SRAMs per accepted event.
//   i_clk, i_rst (async, active-high)
//   i_req_valid / o_req_ready / i_req_pre_addr / i_req_train : event request handshake
//   o_ctrl_synarray_cs/we, o_ctrl_grad_array_cs/we, o_ctrl_synarray_addr : SRAM port controls
//   o_ctrl_post_neuron_address : first post neuron of the word being accessed
//   o_rdata_valid / o_rdata_post_addr : read-only sweep data tag, one cycle behind the read
//   o_busy, o_done (end-of-sweep pulse), o_err (out-of-range request pulse)
module synarray_access_sequencer #(
    parameter int INPUT_NEURON         = 784,
    parameter int OUTPUT_NEURON        = 256,
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int WORD_CNT_WIDTH       = 6,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  i_req_pre_addr,
    input  logic                            i_req_train,
    output logic                            o_ctrl_synarray_cs,
    output logic                            o_ctrl_synarray_we,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] o_ctrl_synarray_addr,
    output logic                            o_ctrl_grad_array_cs,
    output logic                            o_ctrl_grad_array_we,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] o_ctrl_post_neuron_address,
    output logic                            o_rdata_valid,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] o_rdata_post_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err
);
    localparam int WORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam logic [WORD_CNT_WIDTH-1:0] LAST_W = WORD_CNT_WIDTH'(WORDS - 1);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    state_t                          r_state;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  r_pre;
    logic                            r_train;
    logic [WORD_CNT_WIDTH-1:0]       r_w;
    logic                            w_last;
    logic                            w_bad;
    logic                            w_rd_ro;
    logic [WORD_CNT_WIDTH-1:0]       w_w_next;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] w_addr_next;
    logic [POST_NEUR_ADDR_WIDTH-1:0] w_post_next;
    assign w_last      = r_w == LAST_W;
    // Saturate so the counter can never wrap back into the row it just swept.
    assign w_w_next    = w_last ? r_w : r_w + 1'b1;
    assign w_addr_next = SYN_ARRAY_ADDR_WIDTH'({r_pre, w_w_next});
    assign w_post_next = POST_NEUR_ADDR_WIDTH'(32'(w_w_next) * POST_NEUR_PARALLEL);
    assign w_bad       = 32'(i_req_pre_addr) >= INPUT_NEURON;
    assign w_rd_ro     = r_state == RD && !r_train;
    assign o_req_ready = r_state == IDLE;
    assign o_busy      = r_state != IDLE;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state                    <= IDLE;
            r_pre                      <= '0;
            r_train                    <= 1'b0;
            r_w                        <= '0;
            o_ctrl_synarray_cs         <= 1'b0;
            o_ctrl_synarray_we         <= 1'b0;
            o_ctrl_synarray_addr       <= '0;
            o_ctrl_grad_array_cs       <= 1'b0;
            o_ctrl_grad_array_we       <= 1'b0;
            o_ctrl_post_neuron_address <= '0;
            o_rdata_valid              <= 1'b0;
            o_rdata_post_addr          <= '0;
            o_done                     <= 1'b0;
            o_err                      <= 1'b0;
        end else begin
            o_done            <= 1'b0;
            o_err             <= 1'b0;
            // Read data returns one cycle after the read, so the tag trails by one.
            o_rdata_valid     <= w_rd_ro;
            o_rdata_post_addr <= w_rd_ro ? o_ctrl_post_neuron_address : '0;
            case (r_state)
                IDLE: if (i_req_valid) begin
                    if (w_bad) begin
                        o_err <= 1'b1;
                    end else begin
                        r_state                    <= RD;
                        r_pre                      <= i_req_pre_addr;
                        r_train                    <= i_req_train;
                        r_w                        <= '0;
                        o_ctrl_synarray_cs         <= 1'b1;
                        o_ctrl_synarray_we         <= 1'b0;
                        o_ctrl_grad_array_cs       <= i_req_train;
                        o_ctrl_grad_array_we       <= 1'b0;
                        o_ctrl_synarray_addr       <= SYN_ARRAY_ADDR_WIDTH'({i_req_pre_addr, {WORD_CNT_WIDTH{1'b0}}});
                        o_ctrl_post_neuron_address <= '0;
                    end
                end
                RD: begin
                    if (r_train) begin
                        r_state              <= WR;
                        o_ctrl_synarray_we   <= 1'b1;
                        o_ctrl_grad_array_we <= 1'b1;
                    end else if (w_last) begin
                        r_state              <= FIN;
                        o_ctrl_synarray_cs   <= 1'b0;
                        o_ctrl_grad_array_cs <= 1'b0;
                        o_done               <= 1'b1;
                    end else begin
                        r_w                        <= w_w_next;
                        o_ctrl_synarray_addr       <= w_addr_next;
                        o_ctrl_post_neuron_address <= w_post_next;
                    end
                end
                WR: begin
                    o_ctrl_synarray_we   <= 1'b0;
                    o_ctrl_grad_array_we <= 1'b0;
                    if (w_last) begin
                        r_state              <= FIN;
                        o_ctrl_synarray_cs   <= 1'b0;
                        o_ctrl_grad_array_cs <= 1'b0;
                        o_done               <= 1'b1;
                    end else begin
                        r_state                    <= RD;
                        r_w                        <= w_w_next;
                        o_ctrl_synarray_addr       <= w_addr_next;
                        o_ctrl_post_neuron_address <= w_post_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_synarray_access_sequencer.sv
// tb_synarray_access_sequencer: directed and random sweeps checked against a cycle-offset model.
module tb_synarray_access_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_pre = '0;
    logic        req_train = 1'b0;
    logic        syn_cs, syn_we, grad_cs, grad_we;
    logic [15:0] syn_addr;
    logic [9:0]  post_addr;
    logic        rvalid;
    logic [9:0]  rpost;
    logic        busy, done, err;
    int          total = 0;
    int          bad = 0;
    synarray_access_sequencer dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_req_valid                (req_valid),
        .o_req_ready                (req_ready),
        .i_req_pre_addr             (req_pre),
        .i_req_train                (req_train),
        .o_ctrl_synarray_cs         (syn_cs),
        .o_ctrl_synarray_we         (syn_we),
        .o_ctrl_synarray_addr       (syn_addr),
        .o_ctrl_grad_array_cs       (grad_cs),
        .o_ctrl_grad_array_we       (grad_we),
        .o_ctrl_post_neuron_address (post_addr),
        .o_rdata_valid              (rvalid),
        .o_rdata_post_addr          (rpost),
        .o_busy                     (busy),
        .o_done                     (done),
        .o_err                      (err)
    );
    always #5 clk = ~clk;
    function automatic logic [44:0] pack(logic cs, logic we, logic gcs, logic gwe, logic [15:0] a,
                                         logic [9:0] p, logic rv, logic [9:0] rp, logic bsy,
                                         logic dn, logic er, logic rdy);
        return {cs, we, gcs, gwe, a, p, rv, rp, bsy, dn, er, rdy};
    endfunction
    // Addresses only matter while their qualifier is high.
    function automatic logic [44:0] got_vec();
        return pack(syn_cs, syn_we, grad_cs, grad_we, syn_cs ? syn_addr : 16'h0, syn_cs ? post_addr : 10'h0,
                    rvalid, rvalid ? rpost : 10'h0, busy, done, err, req_ready);
    endfunction
    function automatic logic [44:0] got_raw();
        return pack(syn_cs, syn_we, grad_cs, grad_we, syn_addr, post_addr, rvalid, rpost, busy, done, err, req_ready);
    endfunction
    function automatic logic [44:0] idle_vec();
        return pack(0, 0, 0, 0, 16'h0, 10'h0, 0, 10'h0, 0, 0, 0, 1);
    endfunction
    // Expected outputs k cycles after the acceptance cycle of a valid request.
    function automatic logic [44:0] exp_sweep(bit train, int pre, int k);
        int n = train ? 128 : 64;
        int w = 0;
        logic cs = 0, we = 0, gcs = 0, rv = 0, bsy = 0, dn = 0, rdy = 0;
        logic [15:0] a = '0;
        logic [9:0] p = '0, rp = '0;
        if (k <= n) begin
            w   = train ? (k - 1) / 2 : k - 1;
            cs  = 1;
            we  = train && ((k - 1) % 2 == 1);
            gcs = train;
            a   = 16'(pre * 64 + w);
            p   = 10'(w * 4);
            bsy = 1;
        end else if (k == n + 1) begin
            bsy = 1;
            dn  = 1;
        end else begin
            rdy = 1;
        end
        if (!train && k >= 2 && k <= 65) begin
            rv = 1;
            rp = 10'((k - 2) * 4);
        end
        return pack(cs, we, gcs, we, a, p, rv, rp, bsy, dn, 0, rdy);
    endfunction
    task automatic chk(input string tag, input logic [44:0] got, input logic [44:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask
    // noise: 0 = quiet, 1 = random request traffic while busy, 2 = hold a pre=5 request while busy
    task automatic run_req(input int pre, input bit train, input int noise);
        int n = train ? 128 : 64;
        req_valid = 1;
        req_pre   = 10'(pre);
        req_train = train;
        if (pre >= 784) begin
            @(negedge clk);
            req_valid = 0;
            chk($sformatf("err p%0d", pre), got_vec(), pack(0, 0, 0, 0, 16'h0, 10'h0, 0, 10'h0, 0, 0, 1, 1));
            return;
        end
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s p%0d k%0d", train ? "trn" : "rd", pre, k), got_vec(), exp_sweep(train, pre, k));
            if (noise == 1) begin
                req_valid = 1'($urandom_range(0, 1));
                req_pre   = 10'($urandom_range(0, 1023));
                req_train = 1'($urandom_range(0, 1));
            end else if (noise == 2) begin
                req_valid = 1;
                req_pre   = 10'd5;
            end else begin
                req_valid = 0;
            end
        end
        req_valid = 0;
    endtask
    initial begin
        @(negedge clk);
        chk("reset", got_raw(), idle_vec());
        rst = 0;
        @(negedge clk);
        chk("idle", got_vec(), idle_vec());
        run_req(3, 1, 0);
        run_req(783, 0, 0);
        run_req(784, 0, 0);
        run_req(0, 0, 0);
        run_req(9, 1, 2);
        run_req(5, 1, 0);
        run_req(9, 0, 2);
        run_req(5, 0, 0);
        run_req(100, 0, 0);
        run_req(200, 1, 0);
        run_req(1023, 1, 0);
        run_req(783, 1, 0);
        req_valid = 1;
        req_pre   = 10'd7;
        req_train = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_valid = 0;
            chk($sformatf("pre-rst k%0d", k), got_vec(), exp_sweep(1, 7, k));
        end
        #2 rst = 1;
        #1 chk("async rst", got_raw(), idle_vec());
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst %0d", k), got_raw(), idle_vec());
        end
        for (int i = 0; i < 16; i++) begin
            int pre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(784, 1023)) : int'($urandom_range(0, 783));
            int gap = $urandom_range(0, 3);
            run_req(pre, 1'($urandom_range(0, 1)), 1);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("gap %0d", i), got_vec(), idle_vec());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
